// File: rtl/mdu.sv
// mdu: multiply/divide unit with HI/LO registers and fixed multi-cycle latency
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
    localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3, OP_DIVU = 3'd4,
                           OP_MTHI = 3'd5, OP_MTLO = 3'd6;
    typedef enum logic {IDLE, RUN} state_t;
    state_t r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [2:0]    r_op, w_op;
    logic [31:0]   r_a, r_b, r_hi, r_lo, w_a, w_b, w_hi, w_lo;
    logic [63:0]   w_ps, w_pu;
    logic [31:0]   w_ma, w_mb, w_q, w_r, w_dq, w_dr;
    logic          w_sd;
    // Signed division runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no trap
    always_comb begin
        w_ps = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
        w_pu = {32'b0, r_a} * {32'b0, r_b};
        w_sd = r_op == OP_DIV;
        w_ma = (w_sd && r_a[31]) ? -r_a : r_a;
        w_mb = (w_sd && r_b[31]) ? -r_b : r_b;
        w_q  = w_ma / w_mb;
        w_r  = w_ma % w_mb;
        w_dq = (w_sd && (r_a[31] ^ r_b[31])) ? -w_q : w_q;
        w_dr = (w_sd && r_a[31]) ? -w_r : w_r;
    end
    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        w_op   = r_op;
        w_a    = r_a;
        w_b    = r_b;
        w_hi   = r_hi;
        w_lo   = r_lo;
        if (r_state == RUN) begin
            w_cnt = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                w_next = IDLE;
                if (r_op == OP_MULT || r_op == OP_MULTU)
                    {w_hi, w_lo} = r_op == OP_MULT ? w_ps : w_pu;
                else if (r_b != 32'd0) begin
                    w_hi = w_dr;
                    w_lo = w_dq;
                end
            end
        end else if (Start) begin
            if (MDUOp >= OP_MULT && MDUOp <= OP_DIVU) begin
                w_next = RUN;
                w_op   = MDUOp;
                w_a    = SrcA;
                w_b    = SrcB;
                w_cnt  = MDUOp >= OP_DIV ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end
            w_hi = MDUOp == OP_MTHI ? SrcA : r_hi;
            w_lo = MDUOp == OP_MTLO ? SrcA : r_lo;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_op    <= w_op;
            r_a     <= w_a;
            r_b     <= w_b;
            r_hi    <= w_hi;
            r_lo    <= w_lo;
        end
    end
    assign Busy = r_state == RUN;
    assign HI   = r_hi;
    assign LO   = r_lo;
endmodule
